// File: rtl/pattern_timer_param_pkg.sv
// Shared types and helpers for the serial-triggered pattern timer.
// Imported by the interface, the prescaler and the top.
package pattern_timer_param_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Counter width for a modulus, never less than one bit.
    function automatic int min1_clog2(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/pattern_timer_param_if.sv
// Stream, control and status signals of the pattern timer.
// The master drives data/ack/abort; the slave (timer) reports its status.
interface pattern_timer_param_if
    import pattern_timer_param_pkg::*;
#(
    parameter int DELAY_W = 4
);
    logic               data;
    logic               ack;
    logic               abort;
    logic               counting;
    logic               done;
    logic [DELAY_W-1:0] remaining;
    logic [DELAY_W-1:0] delay_value;
    logic [STATE_W-1:0] state;

    modport master (
        output data, ack, abort,
        input  counting, done, remaining, delay_value, state
    );

    modport slave (
        input  data, ack, abort,
        output counting, done, remaining, delay_value, state
    );
endinterface

// File: rtl/pattern_timer_param_tick_prescaler.sv
// Free-running modulo-TICKS counter that pulses tick on its terminal count.
// clear has priority over en; with TICKS=1 tick simply follows en.
module tick_prescaler
    import pattern_timer_param_pkg::*;
#(
    parameter int TICKS = 1000
) (
    input  logic clk,
    input  logic clear,
    input  logic en,
    output logic tick
);
    localparam int                TICK_W = min1_clog2(TICKS);
    localparam logic [TICK_W-1:0] LAST   = TICK_W'(TICKS - 1);

    logic [TICK_W-1:0] count_q;
    logic [TICK_W-1:0] count_d;

    always_comb begin
        tick    = en && (count_q == LAST);
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = tick ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end
endmodule

// File: rtl/pattern_timer_param.sv
// Serial-triggered timer: finds PATTERN in the data stream, shifts in a delay,
// counts (delay+1) units of TICKS_PER_UNIT cycles, then holds done until ack.
module pattern_timer_param
    import pattern_timer_param_pkg::*;
#(
    parameter int                   PATTERN_W      = 4,
    parameter logic [PATTERN_W-1:0] PATTERN        = 4'b1101,
    parameter int                   DELAY_W        = 4,
    parameter int                   TICKS_PER_UNIT = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    pattern_timer_param_if.slave bus
);
    localparam int               BIT_W    = min1_clog2(DELAY_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DELAY_W - 1);

    state_e               state_q, state_d;
    logic [PATTERN_W-2:0] hist_q, hist_d;
    logic [DELAY_W-1:0]   shift_q, shift_d;
    logic [DELAY_W-1:0]   delay_value_q, delay_value_d;
    logic [DELAY_W-1:0]   remaining_q, remaining_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;

    logic [PATTERN_W-1:0] window;
    logic [DELAY_W:0]     shift_window;
    logic                 match;
    logic                 unit_tick;
    logic                 prescale_clear;

    // The window includes the bit being sampled now, so the match edge itself enters SHIFT.
    always_comb begin
        window         = {hist_q, bus.data};
        match          = (window == PATTERN);
        shift_window   = {shift_q, bus.data};
        prescale_clear = reset || (state_q != ST_COUNT) || bus.abort;

        state_d       = state_q;
        hist_d        = '0;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        delay_value_d = delay_value_q;
        remaining_d   = remaining_q;

        case (state_q)
            ST_IDLE: begin
                hist_d      = window[PATTERN_W-2:0];
                shift_d     = '0;
                bit_cnt_d   = '0;
                remaining_d = '0;
                if (match) begin
                    hist_d  = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.abort) begin
                    bit_cnt_d   = '0;
                    remaining_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    shift_d   = shift_window[DELAY_W-1:0];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        delay_value_d = shift_window[DELAY_W-1:0];
                        remaining_d   = shift_window[DELAY_W-1:0];
                        bit_cnt_d     = '0;
                        state_d       = ST_COUNT;
                    end
                end
            end
            // Abort outranks the final unit wrap, so done never rises on an aborted run.
            ST_COUNT: begin
                if (bus.abort) begin
                    remaining_d = '0;
                    state_d     = ST_IDLE;
                end else if (unit_tick) begin
                    if (remaining_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        remaining_d = remaining_q - 1'b1;
                    end
                end
            end
            ST_DONE: begin
                remaining_d = '0;
                if (bus.ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            hist_q        <= '0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            delay_value_q <= '0;
            remaining_q   <= '0;
        end else begin
            state_q       <= state_d;
            hist_q        <= hist_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            delay_value_q <= delay_value_d;
            remaining_q   <= remaining_d;
        end
    end

    tick_prescaler #(
        .TICKS (TICKS_PER_UNIT)
    ) u_prescaler (
        .clk   (clk),
        .clear (prescale_clear),
        .en    (state_q == ST_COUNT),
        .tick  (unit_tick)
    );

    assign bus.counting    = (state_q == ST_COUNT);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.remaining   = remaining_q;
    assign bus.delay_value = delay_value_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_pattern_timer_param.sv
// Scoreboard bench for two pattern_timer_param configurations (1101/4-bit/4 ticks and 101100/3-bit/1 tick).
// Each driven edge queues its expected outputs; a negedge monitor pops and compares.
module tb_pattern_timer_param;

    typedef struct {
        int         sel;
        logic       counting;
        logic       done;
        logic [3:0] remaining;
        logic [3:0] delay_value;
        logic [1:0] state;
    } exp_t;

    bit   clk = 1'b0;
    logic reset;
    exp_t exp_q[$];
    int   n_vectors;
    int   n_miscompares;

    pattern_timer_param_if #(.DELAY_W(4)) if_a ();
    pattern_timer_param_if #(.DELAY_W(3)) if_b ();

    pattern_timer_param #(
        .PATTERN_W      (4),
        .PATTERN        (4'b1101),
        .DELAY_W        (4),
        .TICKS_PER_UNIT (4)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    pattern_timer_param #(
        .PATTERN_W      (6),
        .PATTERN        (6'b101100),
        .DELAY_W        (3),
        .TICKS_PER_UNIT (1)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input exp_t e);
        logic       c, d;
        logic [3:0] r, v;
        logic [1:0] s;
        if (e.sel == 0) begin
            c = if_a.counting; d = if_a.done; r = if_a.remaining; v = if_a.delay_value; s = if_a.state;
        end else begin
            c = if_b.counting; d = if_b.done; r = {1'b0, if_b.remaining};
            v = {1'b0, if_b.delay_value}; s = if_b.state;
        end
        n_vectors++;
        if ({c, d, r, v, s} !== {e.counting, e.done, e.remaining, e.delay_value, e.state}) begin
            n_miscompares++;
            $display("[TB] FAIL vec%0d dut%0d: got cnt=%0b done=%0b rem=%0d dv=%0d st=%0d, want cnt=%0b done=%0b rem=%0d dv=%0d st=%0d",
                     n_vectors, e.sel, c, d, r, v, s,
                     e.counting, e.done, e.remaining, e.delay_value, e.state);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    task automatic applyStimulus(input int sel, input logic rst, input logic d, input logic a,
                                 input logic ab, input logic ec, input logic ed,
                                 input logic [3:0] er, input logic [3:0] ev, input logic [1:0] es);
        exp_t e;
        reset      = rst;
        if_a.data  = (sel == 0) ? d : 1'b0;
        if_a.ack   = (sel == 0) ? a : 1'b0;
        if_a.abort = (sel == 0) ? ab : 1'b0;
        if_b.data  = (sel == 1) ? d : 1'b0;
        if_b.ack   = (sel == 1) ? a : 1'b0;
        if_b.abort = (sel == 1) ? ab : 1'b0;
        @(posedge clk);
        e.sel = sel; e.counting = ec; e.done = ed; e.remaining = er; e.delay_value = ev; e.state = es;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_bits(input int sel, input logic [7:0] bits, input int n, input int shift_at,
                             input logic [3:0] dv);
        for (int i = 0; i < n; i++) begin
            applyStimulus(sel, 1'b0, bits[n-1-i], 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, dv,
                          (i == shift_at) ? 2'd1 : 2'd0);
        end
    endtask

    task automatic shift_bits(input int sel, input logic [3:0] bits, input int n, input logic [3:0] dv_old);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) applyStimulus(sel, 1'b0, bits[n-1-i], 1'b0, 1'b0, 1'b1, 1'b0, bits, bits, 2'd2);
            else            applyStimulus(sel, 1'b0, bits[n-1-i], 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, dv_old, 2'd1);
        end
    endtask

    // Edge 0 (COUNT entry) is checked by shift_bits; edges 1..(D+1)*T-1 stay in COUNT, next is DONE.
    task automatic count_cycles(input int sel, input int dly, input int ticks, input logic ack_in,
                                input logic [3:0] dv);
        for (int j = 1; j < (dly + 1) * ticks; j++) begin
            applyStimulus(sel, 1'b0, 1'b0, ack_in, 1'b0, 1'b1, 1'b0, 4'(dly - j / ticks), dv, 2'd2);
        end
        applyStimulus(sel, 1'b0, 1'b0, ack_in, 1'b0, 1'b0, 1'b1, 4'd0, dv, 2'd3);
    endtask

    task automatic ack_done(input int sel, input logic [3:0] dv);
        applyStimulus(sel, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, dv, 2'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        reset         = 1'b1;
        if_a.data = 1'b0; if_a.ack = 1'b0; if_a.abort = 1'b0;
        if_b.data = 1'b0; if_b.ack = 1'b0; if_b.abort = 1'b0;

        applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0);
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0);

        // Basic run: delay 2, done held until ack, abort and ack ignored where irrelevant.
        idle_bits(0, 8'b1101, 4, 3, 4'd0);
        shift_bits(0, 4'b0010, 4, 4'd0);
        count_cycles(0, 2, 4, 1'b0, 4'd2);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd2, 2'd3);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd2, 2'd3);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd2, 2'd3);
        ack_done(0, 4'd2);
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 2'd0);

        // Overlapping pattern, then a delay that itself looks like the pattern.
        idle_bits(0, 8'b11101, 5, 4, 4'd2);
        shift_bits(0, 4'b1101, 4, 4'd2);
        count_cycles(0, 13, 4, 1'b0, 4'd13);
        ack_done(0, 4'd13);

        // Maximum delay: 64 counting cycles.
        idle_bits(0, 8'b1101, 4, 3, 4'd13);
        shift_bits(0, 4'b1111, 4, 4'd13);
        count_cycles(0, 15, 4, 1'b0, 4'd15);
        ack_done(0, 4'd15);

        // Abort on the 6th COUNT cycle, then a fresh delay-0 run.
        idle_bits(0, 8'b1101, 4, 3, 4'd15);
        shift_bits(0, 4'b0010, 4, 4'd15);
        for (int j = 1; j <= 5; j++) begin
            applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (j < 4) ? 4'd2 : 4'd1, 4'd2, 2'd2);
        end
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 2'd0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 2'd0);
        idle_bits(0, 8'b1101, 4, 3, 4'd2);
        shift_bits(0, 4'b0000, 4, 4'd2);
        count_cycles(0, 0, 4, 1'b0, 4'd0);
        ack_done(0, 4'd0);

        // Abort coinciding with the final wrap: done must never rise.
        idle_bits(0, 8'b1101, 4, 3, 4'd0);
        shift_bits(0, 4'b0000, 4, 4'd0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 2'd2);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 2'd2);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0);

        // Abort during SHIFT leaves delay_value untouched.
        idle_bits(0, 8'b1101, 4, 3, 4'd0);
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd1);
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd1);
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0);

        // Reset mid-COUNT, then ack held high across DONE entry.
        idle_bits(0, 8'b1101, 4, 3, 4'd0);
        shift_bits(0, 4'b0001, 4, 4'd0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 2'd2);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 2'd2);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0);
        idle_bits(0, 8'b1101, 4, 3, 4'd0);
        shift_bits(0, 4'b0000, 4, 4'd0);
        count_cycles(0, 0, 4, 1'b1, 4'd0);
        ack_done(0, 4'd0);

        // Second configuration: 1101 must not trigger, 101100 + 011 gives 4 counting cycles.
        idle_bits(1, 8'b1101, 4, -1, 4'd0);
        idle_bits(1, 8'b0000, 4, -1, 4'd0);
        idle_bits(1, 8'b101100, 6, 5, 4'd0);
        shift_bits(1, 4'b0011, 3, 4'd0);
        count_cycles(1, 3, 1, 1'b0, 4'd3);
        ack_done(1, 4'd3);

        reset = 1'b0;
        if_a.data = 1'b0; if_a.ack = 1'b0; if_a.abort = 1'b0;
        if_b.data = 1'b0; if_b.ack = 1'b0; if_b.abort = 1'b0;
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_miscompares++;
            $display("[TB] FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
